// File: rtl/can_rx_deframer.sv
// CAN 2.0A/2.0B receive deframer: tracks bus integration and frame fields on the
// destuffed bit stream, checks CRC-15 and presents the frame as registered fields.
module can_rx_deframer #(
   parameter int IDLE_BITS = 11
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        bit_in,
   input  logic        bit_valid,
   input  logic        stuff_err,
   output logic        destuff_en,
   output logic        bus_idle,
   output logic [28:0] rx_id,
   output logic        rx_ide,
   output logic        rx_rtr,
   output logic [3:0]  rx_dlc,
   output logic [63:0] rx_data,
   output logic        rx_valid,
   output logic        crc_err,
   output logic        form_err
);

   localparam int ICW = $clog2(IDLE_BITS + 1);

   typedef enum logic [3:0] {
      S_WAIT_IDLE, S_IDLE, S_ID_A, S_SRR_RTR, S_IDE, S_ID_B, S_RTR, S_R1,
      S_R0, S_DLC, S_DATA, S_CRC, S_CRC_DEL, S_ACK_SLOT, S_ACK_DEL, S_EOF
   } state_t;

   state_t           state, state_nxt;
   logic [5:0]       bit_cnt;
   logic [ICW-1:0]   idle_cnt, idle_cnt_nxt;
   logic             rx_valid_nxt, crc_err_nxt, form_err_nxt;
   logic             bit_ok;

   logic [28:0]      id_sr;
   logic             ide_q, rtr_q;
   logic [3:0]       dlc_sr;
   logic [63:0]      data_sr;
   logic [14:0]      crc_calc, crc_rx;

   logic [3:0]       dlc_full;
   logic [3:0]       data_bytes;
   logic [6:0]       data_last;

   function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
      logic nxt;
      nxt = b ^ c[14];
      return {c[13:0], 1'b0} ^ (nxt ? 15'h4599 : 15'h0);
   endfunction

   // a stuff error discards the bit carried in the same cycle
   assign bit_ok     = bit_valid & ~stuff_err;
   assign dlc_full   = {dlc_sr[2:0], bit_in};
   assign data_bytes = dlc_sr[3] ? 4'd8 : {1'b0, dlc_sr[2:0]};
   assign data_last  = {data_bytes, 3'b000} - 7'd1;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= S_WAIT_IDLE;
         idle_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         idle_cnt <= idle_cnt_nxt;
         if (state_nxt != state) bit_cnt <= '0;
         else if (bit_ok)        bit_cnt <= bit_cnt + 6'd1;
      end
   end

   always_comb begin
      state_nxt    = state;
      idle_cnt_nxt = idle_cnt;
      rx_valid_nxt = 1'b0;
      crc_err_nxt  = 1'b0;
      form_err_nxt = 1'b0;
      if (stuff_err && state != S_WAIT_IDLE && state != S_IDLE) begin
         form_err_nxt = 1'b1;
         state_nxt    = S_WAIT_IDLE;
         idle_cnt_nxt = '0;
      end else if (bit_ok) begin
         case (state)
            S_WAIT_IDLE: begin
               if (bit_in) begin
                  idle_cnt_nxt = idle_cnt + ICW'(1);
                  if (idle_cnt == ICW'(IDLE_BITS - 1)) state_nxt = S_IDLE;
               end else begin
                  idle_cnt_nxt = '0;
               end
            end
            S_IDLE:     if (!bit_in) state_nxt = S_ID_A;
            S_ID_A:     if (bit_cnt == 6'd10) state_nxt = S_SRR_RTR;
            S_SRR_RTR:  state_nxt = S_IDE;
            S_IDE:      state_nxt = bit_in ? S_ID_B : S_R0;
            S_ID_B:     if (bit_cnt == 6'd17) state_nxt = S_RTR;
            S_RTR:      state_nxt = S_R1;
            S_R1:       state_nxt = S_R0;
            S_R0:       state_nxt = S_DLC;
            S_DLC: begin
               if (bit_cnt == 6'd3)
                  state_nxt = (rtr_q || dlc_full == 4'd0) ? S_CRC : S_DATA;
            end
            S_DATA:     if ({1'b0, bit_cnt} == data_last) state_nxt = S_CRC;
            S_CRC:      if (bit_cnt == 6'd14) state_nxt = S_CRC_DEL;
            S_CRC_DEL: begin
               if (crc_rx != crc_calc) begin
                  crc_err_nxt  = 1'b1;
                  state_nxt    = S_WAIT_IDLE;
                  idle_cnt_nxt = '0;
               end else if (!bit_in) begin
                  form_err_nxt = 1'b1;
                  state_nxt    = S_WAIT_IDLE;
                  idle_cnt_nxt = '0;
               end else begin
                  state_nxt = S_ACK_SLOT;
               end
            end
            S_ACK_SLOT: state_nxt = S_ACK_DEL;
            S_ACK_DEL: begin
               if (!bit_in) begin
                  form_err_nxt = 1'b1;
                  state_nxt    = S_WAIT_IDLE;
                  idle_cnt_nxt = '0;
               end else begin
                  state_nxt = S_EOF;
               end
            end
            S_EOF: begin
               if (!bit_in) begin
                  form_err_nxt = 1'b1;
                  state_nxt    = S_WAIT_IDLE;
                  idle_cnt_nxt = '0;
               end else if (bit_cnt == 6'd6) begin
                  // intermission: three more recessive bits re-enter IDLE
                  rx_valid_nxt = 1'b1;
                  state_nxt    = S_WAIT_IDLE;
                  idle_cnt_nxt = ICW'(IDLE_BITS - 3);
               end
            end
            default: state_nxt = S_WAIT_IDLE;
         endcase
      end
   end

   // field shift registers and CRC
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         id_sr    <= '0;
         ide_q    <= 1'b0;
         rtr_q    <= 1'b0;
         dlc_sr   <= '0;
         data_sr  <= '0;
         crc_calc <= '0;
         crc_rx   <= '0;
      end else if (bit_ok && !stuff_err) begin
         if (state inside {S_ID_A, S_SRR_RTR, S_IDE, S_ID_B, S_RTR, S_R1, S_R0, S_DLC, S_DATA})
            crc_calc <= crc_step(crc_calc, bit_in);
         case (state)
            S_IDLE: begin
               if (!bit_in) begin
                  id_sr    <= '0;
                  ide_q    <= 1'b0;
                  rtr_q    <= 1'b0;
                  dlc_sr   <= '0;
                  data_sr  <= '0;
                  crc_rx   <= '0;
                  crc_calc <= crc_step(15'h0, bit_in);
               end
            end
            S_ID_A, S_ID_B: id_sr <= {id_sr[27:0], bit_in};
            S_SRR_RTR, S_RTR: rtr_q <= bit_in;
            S_IDE:  ide_q  <= bit_in;
            S_DLC:  dlc_sr <= dlc_full;
            S_DATA: data_sr[6'd63 - bit_cnt] <= bit_in;
            S_CRC:  crc_rx <= {crc_rx[13:0], bit_in};
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         destuff_en <= 1'b0;
         bus_idle   <= 1'b0;
         rx_valid   <= 1'b0;
         crc_err    <= 1'b0;
         form_err   <= 1'b0;
         rx_id      <= '0;
         rx_ide     <= 1'b0;
         rx_rtr     <= 1'b0;
         rx_dlc     <= '0;
         rx_data    <= '0;
      end else begin
         destuff_en <= state_nxt inside {S_IDLE, S_ID_A, S_SRR_RTR, S_IDE, S_ID_B,
                                         S_RTR, S_R1, S_R0, S_DLC, S_DATA, S_CRC};
         bus_idle   <= (state_nxt == S_IDLE);
         rx_valid   <= rx_valid_nxt;
         crc_err    <= crc_err_nxt;
         form_err   <= form_err_nxt;
         if (rx_valid_nxt) begin
            rx_id   <= id_sr;
            rx_ide  <= ide_q;
            rx_rtr  <= rtr_q;
            rx_dlc  <= dlc_sr;
            rx_data <= data_sr;
         end
      end
   end

endmodule

// File: tb/tb_can_rx_deframer.sv
// Scoreboard bench for can_rx_deframer: frames are encoded by the bench with their
// own CRC; expected outcomes are queued at send time and matched on output pulses.
module tb_can_rx_deframer;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        bit_in = 1'b1, bit_valid = 1'b0, stuff_err = 1'b0;
   logic        destuff_en, bus_idle, rx_ide, rx_rtr, rx_valid, crc_err, form_err;
   logic [28:0] rx_id;
   logic [3:0]  rx_dlc;
   logic [63:0] rx_data;

   can_rx_deframer #(.IDLE_BITS(11)) dut (
      .CLK(CLK), .RST_N(RST_N), .bit_in(bit_in), .bit_valid(bit_valid),
      .stuff_err(stuff_err), .destuff_en(destuff_en), .bus_idle(bus_idle),
      .rx_id(rx_id), .rx_ide(rx_ide), .rx_rtr(rx_rtr), .rx_dlc(rx_dlc),
      .rx_data(rx_data), .rx_valid(rx_valid), .crc_err(crc_err), .form_err(form_err)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [2:0]  kind;   // {form_err, crc_err, rx_valid}
      logic [28:0] id;
      logic        ide;
      logic        rtr;
      logic [3:0]  dlc;
      logic [63:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t last_ok = '0;
   exp_t cur;
   logic fbits[$];
   int   data_start, crc_end;
   int   n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (RST_N && (rx_valid || crc_err || form_err)) begin
         if (sb.size() == 0) begin
            chk("unexpected_pulse", {form_err, crc_err, rx_valid}, 3'b000);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("kind", {form_err, crc_err, rx_valid}, e.kind);
            chk("rx_id", rx_id, e.id);
            chk("rx_ide", rx_ide, e.ide);
            chk("rx_rtr", rx_rtr, e.rtr);
            chk("rx_dlc", rx_dlc, e.dlc);
            chk("rx_data", rx_data, e.data);
         end
      end
   end

   function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
      logic n;
      n = b ^ c[14];
      return {c[13:0], 1'b0} ^ (n ? 15'h4599 : 15'h0);
   endfunction

   task automatic build(input logic ide, input logic [28:0] id, input logic rtr,
                        input logic [3:0] dlc, input logic [63:0] data);
      int nb;
      logic [14:0] c;
      fbits.delete();
      fbits.push_back(1'b0);
      for (int i = 10; i >= 0; i--) fbits.push_back(ide ? id[18+i] : id[i]);
      if (ide) begin
         fbits.push_back(1'b1);
         fbits.push_back(1'b1);
         for (int i = 17; i >= 0; i--) fbits.push_back(id[i]);
         fbits.push_back(rtr);
         fbits.push_back(1'b0);
         fbits.push_back(1'b0);
      end else begin
         fbits.push_back(rtr);
         fbits.push_back(1'b0);
         fbits.push_back(1'b0);
      end
      for (int i = 3; i >= 0; i--) fbits.push_back(dlc[i]);
      nb = rtr ? 0 : (dlc > 4'd8 ? 8 : int'(dlc));
      data_start = fbits.size();
      for (int i = 0; i < nb * 8; i++) fbits.push_back(data[63-i]);
      c = '0;
      foreach (fbits[i]) c = crc_step(c, fbits[i]);
      for (int i = 14; i >= 0; i--) fbits.push_back(c[i]);
      crc_end = fbits.size() - 1;
      fbits.push_back(1'b1);   // CRC delimiter
      fbits.push_back(1'b0);   // ACK slot, acknowledged
      fbits.push_back(1'b1);   // ACK delimiter
      repeat (7) fbits.push_back(1'b1);
      cur.kind = 3'b001;
      cur.id   = ide ? id : {18'b0, id[10:0]};
      cur.ide  = ide;
      cur.rtr  = rtr;
      cur.dlc  = dlc;
      cur.data = (nb == 0) ? 64'h0 : (data & (~64'h0 << (64 - 8 * nb)));
   endtask

   task automatic send_bit(input logic b);
      bit_in    = b;
      bit_valid = 1'b1;
      @(posedge CLK);
      #1;
      bit_valid = 1'b0;
   endtask

   task automatic idle_bits(input int n);
      repeat (n) send_bit(1'b1);
   endtask

   // stop_at >= 0 truncates the frame there (with stuff_err on that bit if asked)
   task automatic send_frame(input int stop_at, input bit stop_stuff, input bit live,
                             input bit exp_ok, input bit exp_crc);
      for (int i = 0; i < fbits.size(); i++) begin
         if (i == stop_at) begin
            if (stop_stuff) begin
               stuff_err = 1'b1;
               send_bit(fbits[i]);
               stuff_err = 1'b0;
            end
            return;
         end
         send_bit(fbits[i]);
         if (live && i == crc_end - 1) chk("destuff_en_crc14", destuff_en, 1'b1);
         if (live && i == crc_end)     chk("destuff_en_crc15", destuff_en, 1'b0);
         if (live && i == crc_end + 1) chk("crc_err_timing", crc_err, exp_crc);
         if (live && i == fbits.size() - 1) chk("rx_valid_timing", rx_valid, exp_ok);
      end
   endtask

   task automatic push_ok();
      sb.push_back(cur);
      last_ok = cur;
   endtask

   task automatic push_err(input logic [2:0] kind);
      exp_t e;
      e = last_ok;
      e.kind = kind;
      sb.push_back(e);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ctl"}, {destuff_en, bus_idle, rx_valid, crc_err, form_err,
                          rx_ide, rx_rtr, rx_dlc, rx_id}, 64'h0);
      chk({tag, "_data"}, rx_data, 64'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge CLK);
      #1;
      check_reset_outputs("reset");
      @(negedge CLK);
      RST_N = 1'b1;

      // integration boundary: 10 recessive bits are not enough, the 11th is
      idle_bits(10);
      chk("bus_idle_10", bus_idle, 1'b0);
      chk("destuff_en_10", destuff_en, 1'b0);
      idle_bits(1);
      chk("bus_idle_11", bus_idle, 1'b1);
      chk("destuff_en_11", destuff_en, 1'b1);

      // standard data frame, then back-to-back frames with 3 intermission bits
      build(1'b0, 29'h123, 1'b0, 4'd2, 64'hABCD_1122_3344_5566);
      push_ok();
      send_frame(-1, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("destuff_after_eof", destuff_en, 1'b0);
      idle_bits(3);
      build(1'b1, {11'h155, 18'h2AAAA}, 1'b1, 4'd8, 64'hFFFF_0000_FFFF_0000);
      push_ok();
      send_frame(-1, 1'b0, 1'b1, 1'b1, 1'b0);
      idle_bits(3);
      build(1'b0, 29'h5A5, 1'b0, 4'd15, 64'h0123_4567_89AB_CDEF);
      push_ok();
      send_frame(-1, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("dlc15_data_bits", fbits.size() - data_start, 64 + 15 + 3 + 7);

      // flipped CRC bit; the following frame comes before integration
      idle_bits(3);
      build(1'b0, 29'h3C1, 1'b0, 4'd1, 64'h9600_0000_0000_0000);
      fbits[crc_end - 5] = ~fbits[crc_end - 5];
      push_err(3'b010);
      send_frame(-1, 1'b0, 1'b1, 1'b0, 1'b1);
      build(1'b0, 29'h2AA, 1'b0, 4'd1, 64'h5500_0000_0000_0000);
      send_frame(-1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ignored_not_idle", bus_idle, 1'b0);
      idle_bits(11);
      build(1'b0, 29'h0F0, 1'b0, 4'd3, 64'h1234_5600_0000_0000);
      push_ok();
      send_frame(-1, 1'b0, 1'b1, 1'b1, 1'b0);

      // dominant 4th EOF bit
      idle_bits(3);
      build(1'b0, 29'h111, 1'b0, 4'd1, 64'h4200_0000_0000_0000);
      fbits[fbits.size() - 4] = 1'b0;
      push_err(3'b100);
      send_frame(-1, 1'b0, 1'b1, 1'b0, 1'b0);

      // stuff error in DATA
      idle_bits(11);
      build(1'b0, 29'h222, 1'b0, 4'd2, 64'h3344_0000_0000_0000);
      push_err(3'b100);
      send_frame(data_start + 3, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (2) @(posedge CLK);
      #1;
      chk("stuff_abort_destuff", destuff_en, 1'b0);

      // reset mid-DATA, then integrate and decode
      idle_bits(11);
      build(1'b0, 29'h333, 1'b0, 4'd4, 64'hDEAD_BEEF_0000_0000);
      send_frame(data_start + 5, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge CLK);
      RST_N = 1'b0;
      #1;
      check_reset_outputs("midframe_rst");
      last_ok = '0;
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      idle_bits(11);
      build(1'b1, {11'h7FE, 18'h00301}, 1'b0, 4'd5, 64'h0102_0304_05FF_EEDD);
      push_ok();
      send_frame(-1, 1'b0, 1'b1, 1'b1, 1'b0);

      repeat (5) @(posedge CLK);
      chk("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
